// File: rtl/risc6_mem_port_arbiter.sv
// Three-way arbiter (DBG > MEM > IF) in front of a single-port, 1-cycle-latency RAM,
// with an IF starvation guard and a registered owner tag that steers read returns.
module risc6_mem_port_arbiter #(
  parameter int unsigned AW              = 16,
  parameter int unsigned DW              = 16,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_gnt,
  output logic          mem_stall,
  output logic          mem_rvalid,
  output logic [DW-1:0] mem_rdata,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_stall,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [0:0] {NORMAL, FORCE_IF} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_MEM, OWN_IF} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          if_want;
  logic          g_dbg, g_mem, g_if;

  assign if_want = if_req & ~if_flush;

  // Grant selection; everything is held off while reset is asserted.
  always_comb begin
    g_dbg = 1'b0;
    g_mem = 1'b0;
    g_if  = 1'b0;
    if (!rst) begin
      if (state == FORCE_IF && if_want) g_if  = 1'b1;
      else if (dbg_req)                 g_dbg = 1'b1;
      else if (mem_req)                 g_mem = 1'b1;
      else if (if_want)                 g_if  = 1'b1;
    end
  end

  assign dbg_gnt   = g_dbg;
  assign mem_gnt   = g_mem;
  assign if_gnt    = g_if;
  assign mem_stall = mem_req & ~g_mem & ~rst;
  assign if_stall  = if_want & ~g_if & ~rst;

  // Winner drives the RAM; idle cycles present all-zero.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (g_dbg) begin
      ram_en    = 1'b1;
      ram_we    = dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
    end else if (g_mem) begin
      ram_en    = 1'b1;
      ram_we    = mem_we;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end else if (g_if) begin
      ram_en    = 1'b1;
      ram_addr  = if_addr;
    end
  end

  // Streak counts data grants that overtook a waiting fetch; hitting the limit forces IF next.
  always_comb begin
    streak_nxt = streak;
    if (!if_want || g_if)
      streak_nxt = '0;
    else if ((g_dbg || g_mem) && streak < STREAK_MAX)
      streak_nxt = streak + SW'(1);
    state_nxt = (streak_nxt >= STREAK_MAX) ? FORCE_IF : NORMAL;

    owner_nxt = OWN_NONE;
    if (g_dbg && !dbg_we)      owner_nxt = OWN_DBG;
    else if (g_mem && !mem_we) owner_nxt = OWN_MEM;
    else if (g_if)             owner_nxt = OWN_IF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= NORMAL;
      streak <= '0;
      owner  <= OWN_NONE;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      owner  <= owner_nxt;
    end
  end

  // Read return steering; a flush in the return cycle drops the stale instruction.
  assign dbg_rvalid = (owner == OWN_DBG);
  assign mem_rvalid = (owner == OWN_MEM);
  assign if_rvalid  = (owner == OWN_IF) & ~if_flush;
  assign dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
  assign mem_rdata  = mem_rvalid ? ram_rdata : '0;
  assign if_rdata   = if_rvalid  ? ram_rdata : '0;

endmodule

// File: tb/tb_risc6_mem_port_arbiter.sv
// Directed bench for risc6_mem_port_arbiter: vector table plus reset/streak sequences,
// with a small behavioural RAM behind the arbiter.
module tb_risc6_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_stall, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        if_req, if_flush, if_gnt, if_stall, if_rvalid;
  logic [15:0] if_addr, if_rdata;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;

  logic [15:0] ram [0:255];
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  risc6_mem_port_arbiter #(.AW(16), .DW(16), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_stall(if_stall), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr[7:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
    else passed++;
  endtask

  // Requests must hold addr/we until granted (a flush redirects the fetch).
  logic        p_mreq, p_mgnt, p_mwe, p_ireq, p_ignt, p_ifl;
  logic [15:0] p_maddr, p_iaddr;
  always @(posedge clk) begin
    if (!rst && p_mreq && !p_mgnt && mem_req && (mem_addr !== p_maddr || mem_we !== p_mwe))
      chk("hold_mem_addr", 32'(mem_addr), 32'(p_maddr));
    if (!rst && p_ireq && !p_ignt && !p_ifl && if_req && if_addr !== p_iaddr)
      chk("hold_if_addr", 32'(if_addr), 32'(p_iaddr));
    p_mreq <= mem_req & ~rst;  p_mgnt <= mem_gnt; p_mwe <= mem_we; p_maddr <= mem_addr;
    p_ireq <= if_req & ~rst;   p_ignt <= if_gnt;  p_ifl <= if_flush; p_iaddr <= if_addr;
  end

  typedef struct {
    logic [2:0]  req;   // {dbg, mem, if}
    logic        dwe;
    logic [15:0] daddr, dwd, maddr, iaddr;
    logic        fl;
    logic [2:0]  gnt;   // {dbg, mem, if}
    logic [1:0]  stl;   // {mem, if}
    logic [2:0]  rv;    // {dbg, mem, if}
    logic [15:0] rd;    // data on the one valid return
    logic [1:0]  ram;   // {en, we}
  } vec_t;

  function automatic vec_t mk(input logic [2:0] req, input logic dwe, input logic [15:0] daddr,
                              input logic [15:0] dwd, input logic [15:0] maddr,
                              input logic [15:0] iaddr, input logic fl, input logic [2:0] gnt,
                              input logic [1:0] stl, input logic [2:0] rv,
                              input logic [15:0] rd, input logic [1:0] ram_b);
    vec_t v;
    v.req = req; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.maddr = maddr;
    v.iaddr = iaddr; v.fl = fl; v.gnt = gnt; v.stl = stl; v.rv = rv; v.rd = rd; v.ram = ram_b;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    {dbg_req, mem_req, if_req} = v.req;
    dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
    mem_we = 1'b0;  mem_addr = v.maddr; mem_wdata = 16'h0;
    if_addr = v.iaddr; if_flush = v.fl;
  endtask

  task automatic chk_row(input string nm, input vec_t v);
    chk({nm, " gnt"},   32'({dbg_gnt, mem_gnt, if_gnt}), 32'(v.gnt));
    chk({nm, " stall"}, 32'({mem_stall, if_stall}), 32'(v.stl));
    chk({nm, " rvalid"}, 32'({dbg_rvalid, mem_rvalid, if_rvalid}), 32'(v.rv));
    chk({nm, " dbg_rdata"}, 32'(dbg_rdata), v.rv[2] ? 32'(v.rd) : 32'h0);
    chk({nm, " mem_rdata"}, 32'(mem_rdata), v.rv[1] ? 32'(v.rd) : 32'h0);
    chk({nm, " if_rdata"},  32'(if_rdata),  v.rv[0] ? 32'(v.rd) : 32'h0);
    chk({nm, " ram_en_we"}, 32'({ram_en, ram_we}), 32'(v.ram));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " gnt"}, 32'({dbg_gnt, mem_gnt, if_gnt}), 32'h0);
    chk({nm, " stall"}, 32'({mem_stall, if_stall}), 32'h0);
    chk({nm, " rvalid"}, 32'({dbg_rvalid, mem_rvalid, if_rvalid}), 32'h0);
    chk({nm, " rdata"}, 32'(dbg_rdata | mem_rdata | if_rdata), 32'h0);
    chk({nm, " ram"}, 32'({ram_en, ram_we, ram_addr | ram_wdata}), 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];
  vec_t idle;
  vec_t mi;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);
    ram[65] = 16'h0010;
    idle = mk(3'b000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'b000, 2'b00, 3'b000, 16'h0, 2'b00);

    // Fetch stream 0..6
    for (int i = 0; i < 7; i++)
      vt.push_back(mk(3'b001, 1'b0, 16'h0, 16'h0, 16'h0, 16'(i), 1'b0, 3'b001, 2'b00,
                      (i > 0) ? 3'b001 : 3'b000, (i > 0) ? 16'hA000 + 16'(i - 1) : 16'h0, 2'b10));
    // lw 65 against a fetch
    vt.push_back(mk(3'b011, 1'b0, 16'h0, 16'h0, 16'd65, 16'd7, 1'b0, 3'b010, 2'b01, 3'b001, 16'hA006, 2'b10));
    vt.push_back(mk(3'b001, 1'b0, 16'h0, 16'h0, 16'd65, 16'd7, 1'b0, 3'b001, 2'b00, 3'b010, 16'h0010, 2'b10));
    // 10 cycles of MEM pressure, streak limit 4
    for (int k = 0; k < 10; k++)
      vt.push_back(mk(3'b011, 1'b0, 16'h0, 16'h0, 16'd66, (k < 5) ? 16'd8 : 16'd9, 1'b0,
                      (k == 4 || k == 9) ? 3'b001 : 3'b010, (k == 4 || k == 9) ? 2'b10 : 2'b01,
                      (k == 0 || k == 5) ? 3'b001 : 3'b010,
                      (k == 0) ? 16'hA007 : (k == 5) ? 16'hA008 : 16'hA042, 2'b10));
    vt.push_back(mk(3'b000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'b000, 2'b00, 3'b001, 16'hA009, 2'b00));
    // Branch at PC 4, flush, redirect to 35
    vt.push_back(mk(3'b001, 1'b0, 16'h0, 16'h0, 16'h0, 16'd4,  1'b0, 3'b001, 2'b00, 3'b000, 16'h0, 2'b10));
    vt.push_back(mk(3'b001, 1'b0, 16'h0, 16'h0, 16'h0, 16'd5,  1'b1, 3'b000, 2'b00, 3'b000, 16'h0, 2'b00));
    vt.push_back(mk(3'b001, 1'b0, 16'h0, 16'h0, 16'h0, 16'd35, 1'b0, 3'b001, 2'b00, 3'b000, 16'h0, 2'b10));
    vt.push_back(mk(3'b000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0,  1'b0, 3'b000, 2'b00, 3'b001, 16'hA023, 2'b00));
    // Debug write/read of 35 over MEM and IF
    vt.push_back(mk(3'b111, 1'b1, 16'd35, 16'h0248, 16'd66, 16'd10, 1'b0, 3'b100, 2'b11, 3'b000, 16'h0, 2'b11));
    vt.push_back(mk(3'b111, 1'b0, 16'd35, 16'h0000, 16'd66, 16'd10, 1'b0, 3'b100, 2'b11, 3'b000, 16'h0, 2'b10));
    vt.push_back(mk(3'b011, 1'b0, 16'h0, 16'h0, 16'd66, 16'd10, 1'b0, 3'b010, 2'b01, 3'b100, 16'h0248, 2'b10));
    vt.push_back(mk(3'b001, 1'b0, 16'h0, 16'h0, 16'd66, 16'd10, 1'b0, 3'b001, 2'b00, 3'b010, 16'hA042, 2'b10));
    vt.push_back(mk(3'b000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0,  1'b0, 3'b000, 2'b00, 3'b001, 16'hA00A, 2'b00));

    // Reset with every requester asserted
    rst = 1'b1;
    drive(mk(3'b111, 1'b0, 16'd1, 16'h0, 16'd2, 16'd3, 1'b0, 3'b000, 2'b00, 3'b000, 16'h0, 2'b00));
    #2 chk_zero("reset");
    drive(idle);
    @(negedge clk) rst = 1'b0;
    next_cycle();

    foreach (vt[i]) begin
      drive(vt[i]);
      @(negedge clk) chk_row($sformatf("row%0d", i), vt[i]);
      next_cycle();
    end

    // Streak built to 3, then reset: limit count must restart from 0
    mi = mk(3'b011, 1'b0, 16'h0, 16'h0, 16'd66, 16'd12, 1'b0, 3'b010, 2'b01, 3'b000, 16'h0, 2'b10);
    for (int k = 0; k < 3; k++) begin
      drive(mi);
      @(negedge clk) chk($sformatf("pre_rst%0d gnt", k), 32'({dbg_gnt, mem_gnt, if_gnt}), 32'b010);
      next_cycle();
    end
    rst = 1'b1;
    #1 chk_zero("rst_mid_streak");
    drive(idle);
    @(negedge clk) rst = 1'b0;
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(mi);
      @(negedge clk) begin
        chk($sformatf("post_rst%0d gnt", k), 32'({dbg_gnt, mem_gnt, if_gnt}),
            (k < 4) ? 32'b010 : 32'b001);
        if (k == 0) chk("post_rst0 rvalid", 32'({dbg_rvalid, mem_rvalid, if_rvalid}), 32'h0);
      end
      next_cycle();
    end

    // Reset right after an IF read grant: its return is lost
    drive(mk(3'b001, 1'b0, 16'h0, 16'h0, 16'h0, 16'd5, 1'b0, 3'b001, 2'b00, 3'b000, 16'h0, 2'b10));
    @(negedge clk) chk("pre_rst_if gnt", 32'({dbg_gnt, mem_gnt, if_gnt}), 32'b001);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_zero("rst_after_if");
    drive(idle);
    @(negedge clk) rst = 1'b0;
    next_cycle();
    @(negedge clk) chk("post_rst_if rvalid", 32'({dbg_rvalid, mem_rvalid, if_rvalid}), 32'h0);
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
